config_sequencer: RTL
=====================

CONFIG_SEQUENCER -- requirements
Module: config_sequencer

Interface
REQ-001 Parameter IDLE_ADDR, default 32'hFFFF_FFFF, config_addr value driven when no write is in progress; it matches no tile or section.
REQ-002 Parameter TIMEOUT, default 255, maximum number of consecutive LOAD cycles without cmd_valid before an error is raised; legal range 1..65535.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  a one-cycle pulse that begins a configuration load.
REQ-006 cmd_valid  input  1  a command word is present.
REQ-007 cmd_addr  input  32  target address: [31:16] section ID, [15:0] tile_id.
REQ-008 cmd_data  input  32  configuration payload.
REQ-009 cmd_last  input  1  marks the final command of the load.
REQ-010 cmd_ready  output  1  the sequencer accepts a command this cycle.
REQ-011 config_addr  output  32  registered; broadcast to all tiles.
REQ-012 config_data  output  32  registered; broadcast to all tiles.
REQ-013 busy  output  1  high in LOAD and WRITE.
REQ-014 done  output  1  one-cycle pulse when a load completes.
REQ-015 error  output  1  sticky timeout flag.
REQ-016 word_count  output  16  number of writes issued in the current or most recent load.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, WRITE, DONE and ERR.
REQ-018 IDLE: cmd_ready=0; start moves the FSM to LOAD and clears word_count, error and the timeout counter.
REQ-019 LOAD: cmd_ready=1 combinationally from state. When cmd_valid is high, the sequencer SHALL capture cmd_addr and cmd_data into config_addr and config_data and capture cmd_last, then go to WRITE.
REQ-020 WRITE: config_addr and config_data SHALL hold the captured command for exactly one cycle.
REQ-021 WRITE: word_count SHALL increment by 1.
REQ-022 WRITE: if the captured cmd_last is set, the next state is DONE; otherwise it is LOAD.
REQ-023 On leaving WRITE, config_addr SHALL return to IDLE_ADDR and config_data SHALL return to 0.
REQ-024 Throughput SHALL be at most one write per 2 cycles. Latency from the accepting handshake to config_addr being valid SHALL be 1 cycle.
REQ-025 DONE: done=1 for one cycle, then the FSM returns to IDLE.
REQ-026 The timeout counter SHALL increment on each LOAD cycle with cmd_valid=0 and clear on a handshake. When it reaches TIMEOUT, the FSM SHALL go to ERR and set error.
REQ-027 ERR: cmd_ready=0, busy=0 and config_addr=IDLE_ADDR; start SHALL move the FSM to LOAD and clear error.
REQ-028 start SHALL be ignored in LOAD, WRITE and DONE.
REQ-029 word_count SHALL saturate at 16'hFFFF and never wrap.
REQ-030 A cmd_last command SHALL still produce its write; a load of one command produces exactly one write.
REQ-031 A start arriving together with an in-flight handshake while not in IDLE or ERR SHALL have no effect.

Reset
REQ-032 Reset SHALL return the FSM to IDLE, sampled at clk.
REQ-033 Reset SHALL set config_addr=IDLE_ADDR and config_data=0.
REQ-034 Reset SHALL set busy, done, error, cmd_ready and word_count to 0, and clear the timeout counter.
REQ-035 Reset SHALL take priority over start and over any handshake. Reset mid-WRITE SHALL remove the write in the following cycle.

Configuration
REQ-036 Macro CONFIG_SEQ_CHECKSUM_EN, when defined, SHALL add the output checksum (32 bits). It is cleared on reset and on an accepted start, and XOR-accumulates (config_addr ^ config_data) on each WRITE cycle. Its value is final when done pulses.
REQ-037 When CONFIG_SEQ_CHECKSUM_EN is undefined, the checksum port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-038 Basic load: start, then 3 commands (addr 32'h0004_0001 data 2; 32'h0007_0001 data 32'h1234; 32'h0006_0001 data 5 with last), cmd_valid always high -> three 1-cycle writes 2 cycles apart, done pulses 1 cycle after the third write, word_count=3.
REQ-039 Single command with last set -> exactly one write, done asserted, busy low afterwards, config_addr=32'hFFFF_FFFF.
REQ-040 TIMEOUT=4, start, cmd_valid held low -> error=1 after the 4th LOAD cycle, cmd_ready=0; a new start clears error and reaches LOAD.
REQ-041 Reset asserted during WRITE -> next cycle config_addr=32'hFFFF_FFFF, busy=0, word_count=0, FSM in IDLE.
REQ-042 start pulsed during LOAD and during WRITE -> no change to word_count or sequence; done occurs once.
REQ-043 With CONFIG_SEQ_CHECKSUM_EN defined, run the basic-load stimulus -> checksum equals the XOR of the three (addr^data) values when done pulses.

Source files
------------

// File: rtl/config_sequencer.sv
// Configuration sequencer: accepts command words after a start pulse and broadcasts each one
// to the tiles as a single-cycle address/data write. Optional checksum output: CONFIG_SEQ_CHECKSUM_EN.
module config_sequencer #(
    parameter logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        cmd_last,
    output logic        cmd_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
`ifdef CONFIG_SEQ_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_config_addr;
    logic [31:0] r_config_data;
    logic        r_last;
    logic        r_error;
    logic [15:0] r_word_count;
    logic [15:0] r_timeout_cnt;

    logic        w_handshake;
    logic        w_start_ok;
    logic        w_timeout_hit;

    assign w_handshake   = (r_state == S_LOAD) && cmd_valid;
    // A new load may only be launched from a resting state; start is ignored mid-load.
    assign w_start_ok    = start && ((r_state == S_IDLE) || (r_state == S_ERR));
    assign w_timeout_hit = (r_state == S_LOAD) && !cmd_valid &&
                           (({1'b0, r_timeout_cnt} + 17'd1) >= TIMEOUT_W);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_LOAD;
            S_LOAD: begin
                if (cmd_valid)          w_state_next = S_WRITE;
                else if (w_timeout_hit) w_state_next = S_ERR;
            end
            S_WRITE: w_state_next = r_last ? S_DONE : S_LOAD;
            S_DONE:  w_state_next = S_IDLE;
            S_ERR:   if (start) w_state_next = S_LOAD;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_config_addr <= IDLE_ADDR;
            r_config_data <= 32'd0;
            r_last        <= 1'b0;
            r_error       <= 1'b0;
            r_word_count  <= 16'd0;
            r_timeout_cnt <= 16'd0;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) begin
                r_word_count  <= 16'd0;
                r_timeout_cnt <= 16'd0;
                r_error       <= 1'b0;
            end
            if (w_handshake) begin
                r_config_addr <= cmd_addr;
                r_config_data <= cmd_data;
                r_last        <= cmd_last;
                r_timeout_cnt <= 16'd0;
            end else if (r_state == S_LOAD) begin
                r_timeout_cnt <= r_timeout_cnt + 16'd1;
            end
            if (w_timeout_hit) begin
                r_error <= 1'b1;
            end
            // The write lasts exactly the WRITE cycle; the bus returns to idle afterwards.
            if (r_state == S_WRITE) begin
                r_config_addr <= IDLE_ADDR;
                r_config_data <= 32'd0;
                if (r_word_count != 16'hFFFF) begin
                    r_word_count <= r_word_count + 16'd1;
                end
            end
        end
    end

`ifdef CONFIG_SEQ_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= 32'd0;
        end else if (w_start_ok) begin
            r_checksum <= 32'd0;
        end else if (r_state == S_WRITE) begin
            r_checksum <= r_checksum ^ (r_config_addr ^ r_config_data);
        end
    end

    assign checksum = r_checksum;
`endif

    assign cmd_ready   = (r_state == S_LOAD);
    assign busy        = (r_state == S_LOAD) || (r_state == S_WRITE);
    assign done        = (r_state == S_DONE);
    assign error       = r_error;
    assign config_addr = r_config_addr;
    assign config_data = r_config_data;
    assign word_count  = r_word_count;

endmodule
